// File: rtl/axi_ram_cmd_arb.sv
// Round-robin arbiter sharing one RAM command/response backend between PORTS requesters.
// Grant is held across whole bursts; read responses are steered back via an in-order route FIFO.
module axi_ram_cmd_arb #(
    parameter int PORTS       = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH/8,
    parameter int ID_WIDTH    = 8,
    parameter int ROUTE_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS*ID_WIDTH-1:0]        s_cmd_id,
    input  logic [PORTS*ADDR_WIDTH-1:0]      s_cmd_addr,
    input  logic [PORTS*DATA_WIDTH-1:0]      s_cmd_wr_data,
    input  logic [PORTS*STRB_WIDTH-1:0]      s_cmd_wr_strb,
    input  logic [PORTS-1:0]                 s_cmd_wr_en,
    input  logic [PORTS-1:0]                 s_cmd_rd_en,
    input  logic [PORTS-1:0]                 s_cmd_last,
    output logic [PORTS-1:0]                 s_cmd_ready,
    output logic [ID_WIDTH-1:0]              m_cmd_id,
    output logic [ADDR_WIDTH-1:0]            m_cmd_addr,
    output logic [DATA_WIDTH-1:0]            m_cmd_wr_data,
    output logic [STRB_WIDTH-1:0]            m_cmd_wr_strb,
    output logic                             m_cmd_wr_en,
    output logic                             m_cmd_rd_en,
    output logic                             m_cmd_last,
    input  logic                             m_cmd_ready,
    input  logic [ID_WIDTH-1:0]              m_rd_resp_id,
    input  logic [DATA_WIDTH-1:0]            m_rd_resp_data,
    input  logic                             m_rd_resp_last,
    input  logic                             m_rd_resp_valid,
    output logic                             m_rd_resp_ready,
    output logic [ID_WIDTH-1:0]              s_rd_resp_id,
    output logic [DATA_WIDTH-1:0]            s_rd_resp_data,
    output logic                             s_rd_resp_last,
    output logic [PORTS-1:0]                 s_rd_resp_valid,
    input  logic [PORTS-1:0]                 s_rd_resp_ready,
    output logic                             route_full
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = $clog2(ROUTE_DEPTH);
    localparam int CW = $clog2(ROUTE_DEPTH + 1);

    logic [ID_WIDTH-1:0]   id_a   [PORTS];
    logic [ADDR_WIDTH-1:0] addr_a [PORTS];
    logic [DATA_WIDTH-1:0] data_a [PORTS];
    logic [STRB_WIDTH-1:0] strb_a [PORTS];

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign id_a[i]   = s_cmd_id[i*ID_WIDTH +: ID_WIDTH];
        assign addr_a[i] = s_cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[i] = s_cmd_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a[i] = s_cmd_wr_strb[i*STRB_WIDTH +: STRB_WIDTH];
    end

    logic          locked;
    logic [PW-1:0] grant, last_grant, sel;
    logic          sel_vld, xfer, push, pop;
    logic [PW-1:0] route_mem [ROUTE_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          fifo_full, fifo_empty;
    logic [PW-1:0] head;
    logic [PORTS-1:0] req, elig;

    assign fifo_full  = (count == CW'(ROUTE_DEPTH));
    assign fifo_empty = (count == '0);
    assign req        = s_cmd_wr_en | s_cmd_rd_en;
    // A read may only open a burst if there is room to remember where its responses go.
    assign elig       = req & ~(s_cmd_rd_en & {PORTS{fifo_full}});

    always_comb begin
        sel     = grant;
        sel_vld = 1'b0;
        if (!rst) begin
            if (locked) begin
                sel_vld = req[grant];
            end else begin
                for (int k = 1; k <= PORTS; k++) begin
                    if (!sel_vld && elig[(int'(last_grant) + k) % PORTS]) begin
                        sel_vld = 1'b1;
                        sel     = PW'((int'(last_grant) + k) % PORTS);
                    end
                end
            end
        end
    end

    assign m_cmd_id      = id_a[sel];
    assign m_cmd_addr    = addr_a[sel];
    assign m_cmd_wr_data = data_a[sel];
    assign m_cmd_wr_strb = strb_a[sel];
    assign m_cmd_wr_en   = sel_vld & s_cmd_wr_en[sel];
    assign m_cmd_rd_en   = sel_vld & s_cmd_rd_en[sel];
    assign m_cmd_last    = s_cmd_last[sel];

    always_comb begin
        s_cmd_ready = '0;
        if (sel_vld || locked) s_cmd_ready[sel] = m_cmd_ready;
    end

    assign xfer = sel_vld & m_cmd_ready;
    assign push = xfer & s_cmd_rd_en[sel] & ~locked;
    assign pop  = m_rd_resp_valid & m_rd_resp_ready & m_rd_resp_last;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked     <= 1'b0;
            grant      <= '0;
            last_grant <= PW'(PORTS - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            route_full <= 1'b0;
        end else begin
            if (xfer) begin
                if (s_cmd_last[sel]) begin
                    locked     <= 1'b0;
                    last_grant <= sel;
                end else begin
                    locked <= 1'b1;
                    grant  <= sel;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            route_full <= (count_next == CW'(ROUTE_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) route_mem[wr_ptr] <= sel;
    end

    // Responses are stalled, not dropped, until a route entry exists for them.
    assign head = route_mem[rd_ptr];

    always_comb begin
        s_rd_resp_valid = '0;
        if (m_rd_resp_valid && !fifo_empty) s_rd_resp_valid[head] = 1'b1;
    end

    assign m_rd_resp_ready = ~fifo_empty & s_rd_resp_ready[head];
    assign s_rd_resp_id    = m_rd_resp_id;
    assign s_rd_resp_data  = m_rd_resp_data;
    assign s_rd_resp_last  = m_rd_resp_last;
endmodule
